// File: rtl/acorn128_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | acorn128_pkg : FSM states, phase lengths and ACORN-128 tap indices |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package acorn128_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_AD    = 3'd2,
    ST_ADPAD = 3'd3,
    ST_DEC   = 3'd4,
    ST_CTPAD = 3'd5,
    ST_TAG   = 3'd6
  } state_e;

  localparam logic [10:0] INIT_STEPS    = 11'd1792;
  localparam logic [10:0] PAD_STEPS     = 11'd256;
  localparam logic [10:0] TAG_STEPS     = 11'd768;
  localparam logic [10:0] TAG_CMP_START = 11'd640;
  localparam logic [10:0] PAD_CA_STEPS  = 11'd128;

  localparam int unsigned STATE_W = 293;

  // LFSR boundary taps: each segment head is folded with two inner taps
  localparam int unsigned T_289 = 289;
  localparam int unsigned T_235 = 235;
  localparam int unsigned T_230 = 230;
  localparam int unsigned T_196 = 196;
  localparam int unsigned T_193 = 193;
  localparam int unsigned T_160 = 160;
  localparam int unsigned T_154 = 154;
  localparam int unsigned T_111 = 111;
  localparam int unsigned T_107 = 107;
  localparam int unsigned T_66  = 66;
  localparam int unsigned T_61  = 61;
  localparam int unsigned T_23  = 23;
  localparam int unsigned T_0   = 0;
  localparam int unsigned T_12  = 12;
  localparam int unsigned T_244 = 244;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acorn128_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | acorn128_step : one combinational ACORN-128 state update + ks     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_m,
  input  logic               i_ca,
  input  logic               i_cb,
  input  logic               i_dec,
  output logic [STATE_W-1:0] o_state,
  output logic               o_ks,
  output logic               o_m
);

  logic [STATE_W-1:0] w_s;
  logic               w_f;

  // All six folds read the pre-update state, so their order is irrelevant
  always_comb begin
    w_s        = i_state;
    w_s[T_289] = i_state[T_289] ^ i_state[T_235] ^ i_state[T_230];
    w_s[T_230] = i_state[T_230] ^ i_state[T_196] ^ i_state[T_193];
    w_s[T_193] = i_state[T_193] ^ i_state[T_160] ^ i_state[T_154];
    w_s[T_154] = i_state[T_154] ^ i_state[T_111] ^ i_state[T_107];
    w_s[T_107] = i_state[T_107] ^ i_state[T_66]  ^ i_state[T_61];
    w_s[T_61]  = i_state[T_61]  ^ i_state[T_23]  ^ i_state[T_0];
  end

  assign o_ks = w_s[T_12] ^ w_s[T_154]
              ^ maj(w_s[T_235], w_s[T_61], w_s[T_193])
              ^ ch(w_s[T_230], w_s[T_111], w_s[T_66]);

  assign w_f = w_s[T_0] ^ ~w_s[T_107]
             ^ maj(w_s[T_244], w_s[T_23], w_s[T_160])
             ^ (i_ca & w_s[T_196]) ^ (i_cb & o_ks);

  assign o_m     = i_dec ? (i_m ^ o_ks) : i_m;
  assign o_state = {w_f ^ o_m, w_s[STATE_W-1:1]};

endmodule
`default_nettype wire

// File: rtl/acorn128_decrypt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | acorn128_decrypt : bit-serial ACORN-128 decrypt + tag verify      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module acorn128_decrypt
  import acorn128_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [127:0] i_key,
  input  logic [127:0] i_iv,
  input  logic [127:0] i_tag_in,
  input  logic         i_ad_empty,
  input  logic         i_ct_empty,
  input  logic         i_ad_bit,
  input  logic         i_ad_valid,
  input  logic         i_ad_last,
  output logic         o_ad_ready,
  input  logic         i_ct_bit,
  input  logic         i_ct_valid,
  input  logic         i_ct_last,
  output logic         o_ct_ready,
  output logic         o_pt_bit,
  output logic         o_pt_valid,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_tag_ok
);

  state_e               r_fsm;
  state_e               w_fsm_nxt;
  logic [10:0]          r_cnt;
  logic [STATE_W-1:0]   r_st;
  logic [STATE_W-1:0]   w_st_nxt;
  logic [127:0]         r_key;
  logic [127:0]         r_iv;
  logic [127:0]         r_tag;
  logic                 r_ad_empty;
  logic                 r_ct_empty;
  logic                 r_mis;
  logic                 r_pt_bit;
  logic                 r_pt_valid;
  logic                 r_done;
  logic                 r_tag_ok;

  logic                 w_step;
  logic                 w_m_in;
  logic                 w_ca;
  logic                 w_cb;
  logic                 w_dec;
  logic                 w_cnt_clr;
  logic                 w_cmp;
  logic                 w_fin;
  logic                 w_ks;
  logic                 w_m;
  logic                 w_bad;
  logic                 w_load;
  logic                 w_ct_acc;

  acorn128_step u_step (
    .i_state (r_st),
    .i_m     (w_m_in),
    .i_ca    (w_ca),
    .i_cb    (w_cb),
    .i_dec   (w_dec),
    .o_state (w_st_nxt),
    .o_ks    (w_ks),
    .o_m     (w_m)
  );

  assign w_load   = (r_fsm == ST_IDLE) && i_start;
  assign w_ct_acc = (r_fsm == ST_DEC) && i_ct_valid;
  assign w_bad    = w_cmp && (w_ks != r_tag[r_cnt[6:0]]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_step    = 1'b0;
    w_m_in    = 1'b0;
    w_ca      = 1'b1;
    w_cb      = 1'b1;
    w_dec     = 1'b0;
    w_cnt_clr = 1'b0;
    w_cmp     = 1'b0;
    w_fin     = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (i_start) begin
          w_fsm_nxt = ST_INIT;
          w_cnt_clr = 1'b1;
        end
      end
      ST_INIT: begin
        w_step = 1'b1;
        // key, then iv, then key repeated with bit 0 inverted once at step 256
        if (r_cnt < 11'd128)       w_m_in = r_key[r_cnt[6:0]];
        else if (r_cnt < 11'd256)  w_m_in = r_iv[r_cnt[6:0]];
        else if (r_cnt == 11'd256) w_m_in = ~r_key[0];
        else                       w_m_in = r_key[r_cnt[6:0]];
        if (r_cnt == INIT_STEPS - 11'd1) begin
          w_fsm_nxt = r_ad_empty ? ST_ADPAD : ST_AD;
          w_cnt_clr = 1'b1;
        end
      end
      ST_AD: begin
        w_step = i_ad_valid;
        w_m_in = i_ad_bit;
        if (i_ad_valid && i_ad_last) begin
          w_fsm_nxt = ST_ADPAD;
          w_cnt_clr = 1'b1;
        end
      end
      ST_ADPAD: begin
        w_step = 1'b1;
        w_m_in = (r_cnt == 11'd0);
        w_ca   = (r_cnt < PAD_CA_STEPS);
        if (r_cnt == PAD_STEPS - 11'd1) begin
          w_fsm_nxt = r_ct_empty ? ST_CTPAD : ST_DEC;
          w_cnt_clr = 1'b1;
        end
      end
      ST_DEC: begin
        w_step = i_ct_valid;
        w_m_in = i_ct_bit;
        w_cb   = 1'b0;
        w_dec  = 1'b1;
        if (i_ct_valid && i_ct_last) begin
          w_fsm_nxt = ST_CTPAD;
          w_cnt_clr = 1'b1;
        end
      end
      ST_CTPAD: begin
        w_step = 1'b1;
        w_m_in = (r_cnt == 11'd0);
        w_ca   = (r_cnt < PAD_CA_STEPS);
        w_cb   = 1'b0;
        if (r_cnt == PAD_STEPS - 11'd1) begin
          w_fsm_nxt = ST_TAG;
          w_cnt_clr = 1'b1;
        end
      end
      ST_TAG: begin
        w_step = 1'b1;
        w_cmp  = (r_cnt >= TAG_CMP_START);
        if (r_cnt == TAG_STEPS - 11'd1) begin
          w_fsm_nxt = ST_IDLE;
          w_cnt_clr = 1'b1;
          w_fin     = 1'b1;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_st       <= '0;
      r_key      <= '0;
      r_iv       <= '0;
      r_tag      <= '0;
      r_ad_empty <= 1'b0;
      r_ct_empty <= 1'b0;
      r_mis      <= 1'b0;
      r_pt_bit   <= 1'b0;
      r_pt_valid <= 1'b0;
      r_done     <= 1'b0;
      r_tag_ok   <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 11'd1;
      end

      if (w_load) begin
        r_st       <= '0;
        r_key      <= i_key;
        r_iv       <= i_iv;
        r_tag      <= i_tag_in;
        r_ad_empty <= i_ad_empty;
        r_ct_empty <= i_ct_empty;
        r_mis      <= 1'b0;
        r_tag_ok   <= 1'b0;
      end else begin
        if (w_step) begin
          r_st <= w_st_nxt;
        end
        if (w_bad) begin
          r_mis <= 1'b1;
        end
        // fold in the final compare bit, which lands on the same step as done
        if (w_fin) begin
          r_tag_ok <= ~(r_mis | w_bad);
        end
      end

      r_done     <= w_fin;
      r_pt_valid <= w_ct_acc;
      if (w_ct_acc) begin
        r_pt_bit <= w_m;
      end
    end
  end

  assign o_ad_ready = (r_fsm == ST_AD);
  assign o_ct_ready = (r_fsm == ST_DEC);
  assign o_busy     = (r_fsm != ST_IDLE);
  assign o_pt_bit   = r_pt_bit;
  assign o_pt_valid = r_pt_valid;
  assign o_done     = r_done;
  assign o_tag_ok   = r_tag_ok;

endmodule
`default_nettype wire

// File: tb/tb_acorn128_decrypt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_acorn128_decrypt : random streams vs. a bit-level ACORN model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_acorn128_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [127:0] i_key, i_iv, i_tag_in;
  logic         i_ad_empty, i_ct_empty;
  logic         i_ad_bit, i_ad_valid, i_ad_last, o_ad_ready;
  logic         i_ct_bit, i_ct_valid, i_ct_last, o_ct_ready;
  logic         o_pt_bit, o_pt_valid, o_busy, o_done, o_tag_ok;

  int n_checks = 0;
  int n_errors = 0;

  bit           ad_q[$];
  bit           pt_q[$];
  bit           ct_q[$];
  bit [292:0]   ms;

  always #5 clk = ~clk;

  acorn128_decrypt dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_key      (i_key),
    .i_iv       (i_iv),
    .i_tag_in   (i_tag_in),
    .i_ad_empty (i_ad_empty),
    .i_ct_empty (i_ct_empty),
    .i_ad_bit   (i_ad_bit),
    .i_ad_valid (i_ad_valid),
    .i_ad_last  (i_ad_last),
    .o_ad_ready (o_ad_ready),
    .i_ct_bit   (i_ct_bit),
    .i_ct_valid (i_ct_valid),
    .i_ct_last  (i_ct_last),
    .o_ct_ready (o_ct_ready),
    .o_pt_bit   (o_pt_bit),
    .o_pt_valid (o_pt_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_tag_ok   (o_tag_ok)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mj(input bit x, input bit y, input bit z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Reference update written like the published C code: fold, keystream, feedback, shift
  function automatic bit ref_step(input bit m, input bit ca, input bit cb);
    bit ks, f;
    ms[289] = ms[289] ^ ms[235] ^ ms[230];
    ms[230] = ms[230] ^ ms[196] ^ ms[193];
    ms[193] = ms[193] ^ ms[160] ^ ms[154];
    ms[154] = ms[154] ^ ms[111] ^ ms[107];
    ms[107] = ms[107] ^ ms[66]  ^ ms[61];
    ms[61]  = ms[61]  ^ ms[23]  ^ ms[0];
    ks = ms[12] ^ ms[154] ^ mj(ms[235], ms[61], ms[193])
       ^ (ms[230] ? ms[111] : ms[66]);
    f  = ms[0] ^ ~ms[107] ^ mj(ms[244], ms[23], ms[160])
       ^ (ca & ms[196]) ^ (cb & ks);
    ms = {f ^ m, ms[292:1]};
    return ks;
  endfunction

  // Encrypt pt_q under (k, v, ad_q): fills ct_q and returns the tag
  task automatic ref_encrypt(input logic [127:0] k, input logic [127:0] v, output logic [127:0] tag);
    bit ks;
    ms = '0;
    for (int i = 0; i < 1792; i++) begin
      bit m;
      if (i < 128)       m = k[i];
      else if (i < 256)  m = v[i-128];
      else if (i == 256) m = k[0] ^ 1'b1;
      else               m = k[i % 128];
      void'(ref_step(m, 1'b1, 1'b1));
    end
    foreach (ad_q[i]) void'(ref_step(ad_q[i], 1'b1, 1'b1));
    for (int i = 0; i < 256; i++) void'(ref_step(i == 0, i < 128, 1'b1));
    ct_q.delete();
    foreach (pt_q[i]) begin
      ks = ref_step(pt_q[i], 1'b1, 1'b0);
      ct_q.push_back(pt_q[i] ^ ks);
    end
    for (int i = 0; i < 256; i++) void'(ref_step(i == 0, i < 128, 1'b0));
    tag = '0;
    for (int i = 0; i < 768; i++) begin
      ks = ref_step(1'b0, 1'b1, 1'b1);
      if (i >= 640) tag[i-640] = ks;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_run(input string nm, input logic [127:0] k, input logic [127:0] v,
                        input logic [127:0] t, input bit exp_ok, input bit gaps,
                        input bit stall, input bit poke);
    int n, ai, ci, pi, done_at, stall_cnt, stall_pv;
    bit ade, cte, seen_ready;
    bit [292:0] snap;
    ade = (ad_q.size() == 0);
    cte = (ct_q.size() == 0);
    @(negedge clk);
    i_key = k; i_iv = v; i_tag_in = t;
    i_ad_empty = ade; i_ct_empty = cte;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq({nm, "_busy_rise"}, o_busy, 1);
    n = 0; ai = 0; ci = 0; pi = 0; done_at = -1;
    stall_cnt = 0; stall_pv = 0; seen_ready = 0; snap = '0;
    while (n < 10000) begin
      if (o_pt_valid) begin
        if (pi < pt_q.size()) check_eq({nm, "_pt_bit"}, o_pt_bit, pt_q[pi]);
        else                  check_eq({nm, "_pt_extra"}, 1, 0);
        pi++;
      end
      if (o_done) begin
        done_at = n;
        break;
      end
      if (o_ad_ready || o_ct_ready) seen_ready = 1;
      i_ad_valid = 1'b0;
      i_ct_valid = 1'b0;
      i_start    = poke && (n == 500);
      if (stall_cnt inside {[1:100]}) begin
        stall_cnt++;
        if (o_pt_valid) stall_pv++;
        if (stall_cnt == 101) begin
          check_eq({nm, "_stall_state"}, {31'd0, dut.r_st == snap}, 1);
          check_eq({nm, "_stall_pt"}, stall_pv, 0);
          stall_cnt = 102;
        end
      end
      if (o_ad_ready && ai < ad_q.size() && (!gaps || $urandom_range(0, 2) != 0)) begin
        i_ad_valid = 1'b1;
        i_ad_bit   = ad_q[ai];
        i_ad_last  = (ai == ad_q.size() - 1);
        ai++;
      end
      if (o_ct_ready && stall && stall_cnt == 0 && ci == 20) begin
        snap = dut.r_st;
        stall_cnt = 1;
      end else if (o_ct_ready && ci < ct_q.size() && (stall_cnt == 0 || stall_cnt == 102)
                   && (!gaps || $urandom_range(0, 2) != 0)) begin
        i_ct_valid = 1'b1;
        i_ct_bit   = ct_q[ci];
        i_ct_last  = (ci == ct_q.size() - 1);
        ci++;
      end
      @(negedge clk);
      n++;
    end
    i_ad_valid = 1'b0;
    i_ct_valid = 1'b0;
    i_start    = 1'b0;
    check_eq({nm, "_done_seen"}, {31'd0, done_at >= 0}, 1);
    if (ade && cte) begin
      check_eq({nm, "_done_latency"}, done_at, 3072);
      check_eq({nm, "_ready_never"}, seen_ready, 0);
    end
    check_eq({nm, "_tag_ok"}, o_tag_ok, exp_ok);
    check_eq({nm, "_pt_count"}, pi, pt_q.size());
    @(negedge clk);
    check_eq({nm, "_done_pulse"}, o_done, 0);
    check_eq({nm, "_busy_fall"}, o_busy, 0);
    check_eq({nm, "_tag_hold"}, o_tag_ok, exp_ok);
  endtask

  initial begin
    logic [127:0] k, v, tg, tb;
    rst = 1'b1; i_start = 1'b0;
    i_key = '0; i_iv = '0; i_tag_in = '0; i_ad_empty = 1'b0; i_ct_empty = 1'b0;
    i_ad_bit = 1'b0; i_ad_valid = 1'b0; i_ad_last = 1'b0;
    i_ct_bit = 1'b0; i_ct_valid = 1'b0; i_ct_last = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {o_busy, o_done, o_tag_ok, o_pt_valid, o_ad_ready, o_ct_ready}, 0);
    rst = 1'b0;

    // zero key/iv, no AD, no ciphertext
    ad_q.delete(); pt_q.delete();
    ref_encrypt('0, '0, tg);
    do_run("zero", '0, '0, tg, 1'b1, 1'b0, 1'b0, 1'b0);

    tb = tg; tb[127] = ~tb[127];
    do_run("badtag", '0, '0, tb, 1'b0, 1'b0, 1'b0, 1'b0);

    // 16 AD bits + 64 ciphertext bits with gaps and a 100-cycle stall
    k = rand128(); v = rand128();
    ad_q.delete(); pt_q.delete();
    for (int i = 0; i < 16; i++) ad_q.push_back(1'($urandom));
    for (int i = 0; i < 64; i++) pt_q.push_back(1'($urandom));
    ref_encrypt(k, v, tg);
    do_run("stream", k, v, tg, 1'b1, 1'b1, 1'b1, 1'b0);

    // reset in the middle of INIT, then a clean run
    k = rand128(); v = rand128();
    ad_q.delete(); pt_q.delete();
    ref_encrypt(k, v, tg);
    @(negedge clk);
    i_key = k; i_iv = v; i_tag_in = tg; i_ad_empty = 1'b1; i_ct_empty = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (900) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_outputs", {o_busy, o_done, o_tag_ok, o_pt_valid, o_ad_ready, o_ct_ready}, 0);
      check_eq("midrst_state", {31'd0, dut.r_st == 293'd0}, 1);
    end
    rst = 1'b0;
    do_run("after_rst", k, v, tg, 1'b1, 1'b0, 1'b0, 1'b0);

    // extra start pulse while busy must be ignored
    k = rand128(); v = rand128();
    ref_encrypt(k, v, tg);
    do_run("poke", k, v, tg, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
